uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller: synchronises the asynchronous serial line, detects start bits with 16x oversampling, and samples each bit at mid-period. It sits directly upstream of the receive shift register, driving its shift/load controls and serial input, then reads the assembled byte back from the register's `q` output. It also checks the optional parity bit and the stop bit, and presents the received byte with a one-cycle valid strobe to the controller's host side.

## Interface
Parameters:
- `PARITY_EN`, default 0: 1 = frame carries a parity bit between data and stop.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `baud_tick16`  in  1  one-`clk` pulse at 16x baud rate.
- `rx`  in  1  asynchronous serial line; idles high.
- `sr_shift_en`  out  1  shift strobe to the shift register.
- `sr_load_en`  out  1  parallel-load strobe to the shift register.
- `sr_serial_in`  out  1  sampled bit presented with `sr_shift_en`.
- `sr_parallel_in`  out  9  load value; constant 9'h000.
- `sr_q`  in  9  shift register contents; byte is read from `sr_q[7:0]`.
- `data`  out  8  last received byte; holds until the next valid frame.
- `data_valid`  out  1  one-cycle pulse: `data` updated.
- `parity_err`  out  1  sticky-per-frame: parity mismatch on the last frame.
- `framing_err`  out  1  sticky-per-frame: stop bit sampled 0 on the last frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. `rx_s` denotes its output.
- A 4-bit `tick_cnt` advances only on `baud_tick16`. A 3-bit `bit_cnt` counts data bits.
- States (enum `rx_state_e`):
  - IDLE: on a falling edge of `rx_s` (previous 1, current 0):
    - clear `tick_cnt`;
    - pulse `sr_load_en` for one cycle, which clears the register;
    - go to START.
  - START: on the 8th tick (mid-bit), sample `rx_s`. If 1, this is a false start: go to IDLE with no outputs. If 0, clear `tick_cnt`, clear `bit_cnt`, and go to DATA.
  - DATA: on every 16th tick, sample `rx_s`. Drive `sr_serial_in` = sample and `sr_shift_en` = 1 for exactly one cycle. Accumulate the parity XOR. After the 8th bit (`bit_cnt`=7), go to PARITY if `PARITY_EN`, else go to STOP.
  - PARITY: on the 16th tick, sample `rx_s`. Mismatch is computed as the XOR of the 8 data bits XOR the parity bit XOR `PARITY_ODD`; a mismatch sets the parity-error flag. Go to STOP.
  - STOP: on the 16th tick, sample `rx_s`.
    - Latch `data` ← `sr_q[7:0]`. The LSB is the first bit received.
    - Update `parity_err` and `framing_err` (framing error = sample 0).
    - Pulse `data_valid`.
    - Go to IDLE.
- A byte is delivered even when it carries an error; the error flags qualify it.
- Both error flags update only on a `data_valid` cycle.
- `sr_shift_en` and `sr_load_en` are never high in the same cycle.
- Break or stuck-low line: IDLE requires a true 1→0 edge, so a line held low after a framing error does not retrigger reception.
- The shift register's `q[8]` is ignored.

## Timing
- Reset values: state IDLE; `sr_shift_en`, `sr_load_en`, `sr_serial_in`, `data_valid`, `parity_err`, `framing_err`, `busy` all 0; `data` = 8'h00; `tick_cnt` and `bit_cnt` 0; synchroniser flops 1.
- Synchroniser latency: 2 `clk` cycles from `rx` to `rx_s`.
- Every strobe and control output is registered: it asserts in the cycle after the qualifying `baud_tick16` sample.
- `data_valid` asserts in the cycle after the stop-bit sample tick. By then `sr_q` has been stable for at least 15 ticks.
- `baud_tick16` is ignored in IDLE.
- A falling edge that coincides with `data_valid` is accepted, because IDLE is entered on the same edge as `data_valid`. Edge detection uses the registered previous `rx_s`.
- Reset asserted mid-frame:
  - immediate return to reset values;
  - no `data_valid`, no partial byte;
  - `data` returns to 8'h00.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE`=16, `MID_SAMPLE`=8, `DATA_BITS`=8.
- Sub-module `sync_2ff`: parameterised reset value, used for `rx`.
- The shift register stays external. `uart_rx_ctrl` connects to it through the `sr_*` ports.

## Test plan
- 8N1 frame carrying 8'hA5, with the bench shift register attached → exactly 8 `sr_shift_en` pulses with bits 1,0,1,0,0,1,0,1; `data`=8'hA5; one `data_valid`; both error flags 0.
- Glitch low on `rx` lasting 4 ticks → false start; return to IDLE; no shift pulses; no `data_valid`; `busy` low again.
- `PARITY_EN`=1, even parity, 8'h03 with parity bit 1 → `parity_err`=1 and `data`=8'h03. Repeat with parity bit 0 → `parity_err`=0.
- Stop bit driven 0 on 8'h5A, line then held low for 40 ticks → `framing_err`=1 and `data`=8'h5A; no new frame until `rx` rises and falls again.
- Reset asserted after 4 data bits → all outputs at reset values; the next clean frame 8'hC3 is received correctly.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap → two `data_valid` pulses; `data` goes 8'h00 then 8'hFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The frame-timing constants are pre-sized to the counter widths they compare against.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    // Terminal counts, sized to the 4-bit tick counter and the 3-bit bit counter.
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops take RESET_VAL on reset, so an idle-high line never shows a spurious edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampled start detection and mid-bit sampling.
// Shift and load commands go to an external shift register; the finished byte is read back from it.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick16,
    input  logic       rx,
    output logic       sr_shift_en,
    output logic       sr_load_en,
    output logic       sr_serial_in,
    output logic [8:0] sr_parallel_in,
    input  logic [8:0] sr_q,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       busy
);

    rx_state_e  state, state_next;
    logic [3:0] tick_cnt, tick_next;
    logic [2:0] bit_cnt, bit_next;
    logic       par_acc, par_acc_next;
    logic       par_mis, par_mis_next;

    logic       rx_s;
    logic       rx_prev;
    logic       rx_fall;

    logic       shift_next;
    logic       load_next;
    logic       serial_next;
    logic       valid_next;
    logic [7:0] data_next;
    logic       perr_next;
    logic       ferr_next;

    // Bit 8 of the shift register never carries frame data.
    logic       sr_q_unused;
    assign sr_q_unused = sr_q[8];

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    // A start needs a real 1->0 transition; a line held low after a bad stop bit cannot retrigger.
    assign rx_fall        = rx_prev & ~rx_s;
    assign sr_parallel_in = 9'h000;
    assign busy           = (state != IDLE);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        tick_next    = tick_cnt;
        bit_next     = bit_cnt;
        par_acc_next = par_acc;
        par_mis_next = par_mis;
        shift_next   = 1'b0;
        load_next    = 1'b0;
        serial_next  = sr_serial_in;
        valid_next   = 1'b0;
        data_next    = data;
        perr_next    = parity_err;
        ferr_next    = framing_err;

        unique case (state)
            IDLE: begin
                if (rx_fall) begin
                    tick_next  = '0;
                    load_next  = 1'b1;
                    state_next = START;
                end
            end

            START: begin
                if (baud_tick16) begin
                    if (tick_cnt == TICK_MID) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            tick_next    = '0;
                            bit_next     = '0;
                            par_acc_next = 1'b0;
                            par_mis_next = 1'b0;
                            state_next   = DATA;
                        end
                    end else begin
                        tick_next = tick_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (baud_tick16) begin
                    // The counter wraps to 0 on the sampling tick, which starts the next bit period.
                    tick_next = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        shift_next   = 1'b1;
                        serial_next  = rx_s;
                        par_acc_next = par_acc ^ rx_s;
                        bit_next     = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = PARITY_EN ? PARITY : STOP;
                        end
                    end
                end
            end

            PARITY: begin
                if (baud_tick16) begin
                    tick_next = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        par_mis_next = par_acc ^ rx_s ^ PARITY_ODD;
                        state_next   = STOP;
                    end
                end
            end

            STOP: begin
                if (baud_tick16) begin
                    tick_next = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        data_next  = sr_q[7:0];
                        perr_next  = par_mis;
                        ferr_next  = ~rx_s;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            par_acc      <= 1'b0;
            par_mis      <= 1'b0;
            rx_prev      <= 1'b1;
            sr_shift_en  <= 1'b0;
            sr_load_en   <= 1'b0;
            sr_serial_in <= 1'b0;
            data_valid   <= 1'b0;
            data         <= 8'h00;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_next;
            bit_cnt      <= bit_next;
            par_acc      <= par_acc_next;
            par_mis      <= par_mis_next;
            rx_prev      <= rx_s;
            sr_shift_en  <= shift_next;
            sr_load_en   <= load_next;
            sr_serial_in <= serial_next;
            data_valid   <= valid_next;
            data         <= data_next;
            parity_err   <= perr_next;
            framing_err  <= ferr_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance, each with its own shift register.
// Expected results come from the transmitted frame itself.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick16 = 1'b0;
    logic [1:0] div = 2'd0;
    int tick_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div         <= div + 2'd1;
        baud_tick16 <= (div == 2'd3);
        if (baud_tick16) tick_count <= tick_count + 1;
    end

    // 8N1 instance
    logic       rx = 1'b1;
    logic       sr_shift_en, sr_load_en, sr_serial_in;
    logic [8:0] sr_parallel_in, sr_q;
    logic [7:0] data;
    logic       data_valid, parity_err, framing_err, busy;

    uart_rx_ctrl #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .baud_tick16(baud_tick16), .rx(rx),
        .sr_shift_en(sr_shift_en), .sr_load_en(sr_load_en), .sr_serial_in(sr_serial_in),
        .sr_parallel_in(sr_parallel_in), .sr_q(sr_q),
        .data(data), .data_valid(data_valid), .parity_err(parity_err),
        .framing_err(framing_err), .busy(busy)
    );

    // 8E1 instance
    logic       rx_p = 1'b1;
    logic       sr_shift_en_p, sr_load_en_p, sr_serial_in_p;
    logic [8:0] sr_parallel_in_p, sr_q_p;
    logic [7:0] data_p;
    logic       data_valid_p, parity_err_p, framing_err_p, busy_p;

    uart_rx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .clk(clk), .rst(rst), .baud_tick16(baud_tick16), .rx(rx_p),
        .sr_shift_en(sr_shift_en_p), .sr_load_en(sr_load_en_p), .sr_serial_in(sr_serial_in_p),
        .sr_parallel_in(sr_parallel_in_p), .sr_q(sr_q_p),
        .data(data_p), .data_valid(data_valid_p), .parity_err(parity_err_p),
        .framing_err(framing_err_p), .busy(busy_p)
    );

    // Receive shift registers: shift right into bit 7, so the first bit lands in bit 0.
    always @(posedge clk or posedge rst) begin
        if (rst)              sr_q <= '0;
        else if (sr_load_en)  sr_q <= sr_parallel_in;
        else if (sr_shift_en) sr_q <= {1'b0, sr_serial_in, sr_q[7:1]};
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                sr_q_p <= '0;
        else if (sr_load_en_p)  sr_q_p <= sr_parallel_in_p;
        else if (sr_shift_en_p) sr_q_p <= {1'b0, sr_serial_in_p, sr_q_p[7:1]};
    end

    // Output monitors sample on the falling edge.
    logic       shift_q[$];
    logic [9:0] valid_q[$];
    logic [9:0] valid_q_p[$];
    int         overlap = 0;

    always @(negedge clk) begin
        if (sr_shift_en) shift_q.push_back(sr_serial_in);
        if (data_valid) valid_q.push_back({framing_err, parity_err, data});
        if (data_valid_p) valid_q_p.push_back({framing_err_p, parity_err_p, data_p});
        if ((sr_shift_en && sr_load_en) || (sr_shift_en_p && sr_load_en_p)) overlap++;
    end

    int tests  = 0;
    int failed = 0;

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic drive(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else      rx   = v;
    endtask

    task automatic send_frame(input bit to_p, input logic [7:0] b, input bit with_par,
                              input logic pbit, input logic stop);
        drive(to_p, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(to_p, b[i]);
            wait_ticks(16);
        end
        if (with_par) begin
            drive(to_p, pbit);
            wait_ticks(16);
        end
        drive(to_p, stop);
        wait_ticks(16);
    endtask

    task automatic clear_logs();
        shift_q.delete();
        valid_q.delete();
        valid_q_p.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (data !== 8'h00) begin failed++; $display("FAIL reset_data: got %h want 00", data); end
        tests++; if ({sr_shift_en, sr_load_en, sr_serial_in, data_valid} !== 4'b0000) begin
            failed++; $display("FAIL reset_strobes: got %b want 0000", {sr_shift_en, sr_load_en, sr_serial_in, data_valid}); end
        tests++; if ({parity_err, framing_err, busy} !== 3'b000) begin
            failed++; $display("FAIL reset_flags: got %b want 000", {parity_err, framing_err, busy}); end
        tests++; if (sr_parallel_in !== 9'h000) begin failed++; $display("FAIL reset_pin: got %h want 000", sr_parallel_in); end
        tests++; if ({busy_p, data_valid_p, data_p} !== 10'h000) begin
            failed++; $display("FAIL reset_par_dut: got %h want 000", {busy_p, data_valid_p, data_p}); end
    endtask

    task automatic test_8n1_a5();
        logic [7:0] got;
        clear_logs();
        drive(1'b0, 1'b0);
        wait_ticks(4);
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL a5_busy: got %b want 1", busy); end
        wait_ticks(12);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'hA5 >> i);
            wait_ticks(16);
        end
        drive(1'b0, 1'b1);
        wait_ticks(20);
        tests++; if (shift_q.size() != 8) begin failed++; $display("FAIL a5_shift_count: got %0d want 8", shift_q.size()); end
        got = '0;
        foreach (shift_q[i]) if (i < 8) got[i] = shift_q[i];
        tests++; if (got !== 8'hA5) begin failed++; $display("FAIL a5_shift_bits: got %h want a5", got); end
        tests++; if (valid_q.size() != 1) begin failed++; $display("FAIL a5_valid_count: got %0d want 1", valid_q.size()); end
        tests++; if (data !== 8'hA5) begin failed++; $display("FAIL a5_data: got %h want a5", data); end
        tests++; if ({parity_err, framing_err, busy} !== 3'b000) begin
            failed++; $display("FAIL a5_flags: got %b want 000", {parity_err, framing_err, busy}); end
    endtask

    task automatic test_false_start();
        clear_logs();
        drive(1'b0, 1'b0);
        wait_ticks(4);
        drive(1'b0, 1'b1);
        wait_ticks(24);
        tests++; if (shift_q.size() != 0) begin failed++; $display("FAIL glitch_shift: got %0d want 0", shift_q.size()); end
        tests++; if (valid_q.size() != 0) begin failed++; $display("FAIL glitch_valid: got %0d want 0", valid_q.size()); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL glitch_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity();
        clear_logs();
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        wait_ticks(2);
        tests++; if (valid_q_p.size() != 1 || valid_q_p[0] !== {2'b01, 8'h03}) begin
            failed++; $display("FAIL parity_bad: got %0d entries, flags+data %h want 103", valid_q_p.size(), {framing_err_p, parity_err_p, data_p}); end
        clear_logs();
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_ticks(2);
        tests++; if (valid_q_p.size() != 1 || valid_q_p[0] !== {2'b00, 8'h03}) begin
            failed++; $display("FAIL parity_good: got %0d entries, flags+data %h want 003", valid_q_p.size(), {framing_err_p, parity_err_p, data_p}); end
    endtask

    task automatic test_framing();
        clear_logs();
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        tests++; if (valid_q.size() != 1) begin failed++; $display("FAIL frame_valid_count: got %0d want 1", valid_q.size()); end
        tests++; if ({framing_err, data} !== {1'b1, 8'h5A}) begin
            failed++; $display("FAIL frame_err: got %h want 15a", {framing_err, data}); end
        tests++; if (shift_q.size() != 8 || busy !== 1'b0) begin
            failed++; $display("FAIL frame_no_retrigger: got shifts %0d busy %b want 8 0", shift_q.size(), busy); end
        drive(1'b0, 1'b1);
        wait_ticks(4);
        clear_logs();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        tests++; if (valid_q.size() != 1 || {framing_err, data} !== {1'b0, 8'h3C}) begin
            failed++; $display("FAIL frame_recover: got %0d entries %h want 1 03c", valid_q.size(), {framing_err, data}); end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        drive(1'b0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h96 >> i);
            wait_ticks(16);
        end
        rst = 1'b1;
        drive(1'b0, 1'b1);
        @(negedge clk);
        tests++; if ({busy, data_valid, sr_shift_en, sr_load_en, sr_serial_in, parity_err, framing_err} !== 7'b0) begin
            failed++; $display("FAIL midrst_ctrl: got %b want 0000000",
                {busy, data_valid, sr_shift_en, sr_load_en, sr_serial_in, parity_err, framing_err}); end
        tests++; if (data !== 8'h00) begin failed++; $display("FAIL midrst_data: got %h want 00", data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);
        tests++; if (valid_q.size() != 0) begin failed++; $display("FAIL midrst_no_valid: got %0d want 0", valid_q.size()); end
        clear_logs();
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        tests++; if (valid_q.size() != 1 || {framing_err, data} !== {1'b0, 8'hC3}) begin
            failed++; $display("FAIL midrst_next_frame: got %0d entries %h want 1 0c3", valid_q.size(), {framing_err, data}); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        tests++; if (valid_q.size() != 2) begin failed++; $display("FAIL b2b_count: got %0d want 2", valid_q.size()); end
        else begin
            tests++; if (valid_q[0][7:0] !== 8'h00 || valid_q[1][7:0] !== 8'hFF) begin
                failed++; $display("FAIL b2b_data: got %h,%h want 00,ff", valid_q[0][7:0], valid_q[1][7:0]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       pbit, stop, got_ok;
        logic [7:0] got;
        logic [9:0] exp;
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            drive(1'b0, 1'b1);
            wait_ticks($urandom_range(1, 10));
            clear_logs();
            send_frame(1'b0, b, 1'b0, 1'b0, stop);
            wait_ticks(2);
            got = '0;
            foreach (shift_q[i]) if (i < 8) got[i] = shift_q[i];
            exp = {~stop, 1'b0, b};
            got_ok = (valid_q.size() == 1) && (valid_q[0] === exp) && (shift_q.size() == 8) && (got === b);
            tests++; if (!got_ok) begin
                failed++; $display("FAIL rand_8n1[%0d]: got %0d entries %h shifted %h want %h", n, valid_q.size(),
                    {framing_err, parity_err, data}, got, exp); end
        end
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            drive(1'b1, 1'b1);
            wait_ticks($urandom_range(1, 10));
            clear_logs();
            send_frame(1'b1, b, 1'b1, pbit, stop);
            wait_ticks(2);
            // Even parity: total count of ones across data and parity bit must be even.
            exp = {~stop, (^b) ^ pbit, b};
            tests++; if (valid_q_p.size() != 1 || valid_q_p[0] !== exp) begin
                failed++; $display("FAIL rand_8e1[%0d]: got %0d entries %h want %h", n, valid_q_p.size(),
                    {framing_err_p, parity_err_p, data_p}, exp); end
        end
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
    endtask

    task automatic test_strobe_exclusive();
        tests++; if (overlap != 0) begin failed++; $display("FAIL shift_load_overlap: got %0d want 0", overlap); end
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        test_reset();
        wait_ticks(2);
        test_8n1_a5();
        test_false_start();
        test_parity();
        test_framing();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_strobe_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
